vector_serializer_16: RTL and testbench

//  Parallel-to-serial stage for 16-element vectors of M-bit elements.

---
 rtl/serializer_pkg.sv | 16 +
 rtl/multiplexer_16to1.sv | 18 +
 rtl/vector_serializer_16.sv | 92 +++++++++
 tb/tb_vector_serializer_16.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/serializer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serializer_pkg
// Purpose  : Shared sizes and FSM state type for the vector serializer.
// Revision : 1.0 - initial release
// ============================================================================
package serializer_pkg;
  localparam int NUM_ELEM = 16;
  localparam int IDX_W    = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    SERIAL = 1'b1
  } state_t;
endpackage
`default_nettype wire

// File: rtl/multiplexer_16to1.sv
`default_nettype none
// ============================================================================
// Module   : multiplexer_16to1
// Purpose  : Plain 16:1 multiplexer of M-bit lanes; lane j = in_data[j*M +: M].
// Revision : 1.0 - initial release
// ============================================================================
module multiplexer_16to1 #(
  parameter int M = 8
) (
  input  logic [16*M-1:0] in_data,
  input  logic [3:0]      sel,
  output logic [M-1:0]    out_data
);
  always_comb begin
    out_data = in_data[sel*M +: M];
  end
endmodule
`default_nettype wire

// File: rtl/vector_serializer_16.sv
`default_nettype none
// ============================================================================
// Module   : vector_serializer_16
// Purpose  : Accepts a 16-element vector and streams elements 0..last_idx
//            one per cycle on a valid/ready interface with a last flag.
// Revision : 1.0 - initial release
// ============================================================================
module vector_serializer_16 #(
  parameter int M = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [16*M-1:0] in_data,
  input  logic [3:0]    in_last_idx,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [M-1:0]  out_data,
  output logic          out_last,
  output logic          busy
);
  import serializer_pkg::*;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [NUM_ELEM*M-1:0]   r_vec;
  logic [IDX_W-1:0]        r_last;
  logic [IDX_W-1:0]        r_idx;
  logic [IDX_W-1:0]        w_sel;
  logic [NUM_ELEM*M-1:0]   w_mux_in;
  logic                    w_serial;
  logic                    w_at_last;
  logic                    w_beat;
  logic                    w_load;

  assign w_serial  = (r_state == SERIAL);
  assign w_at_last = w_serial && (r_idx == r_last);
  assign w_beat    = w_serial && out_ready;
  assign in_ready  = !rst && ((r_state == IDLE) || (w_beat && w_at_last));
  assign w_load    = in_valid && in_ready;

  assign out_valid = w_serial;
  assign out_last  = w_at_last;
  assign busy      = w_serial;

  // The mux decodes sel with bits [3:2] inverted, so lane j carries element j^12.
  assign w_sel = {~r_idx[3:2], r_idx[1:0]};

  for (genvar j = 0; j < NUM_ELEM; j++) begin : g_perm
    localparam int c_ELEM = j ^ 12;
    assign w_mux_in[j*M +: M] = r_vec[c_ELEM*M +: M];
  end

  multiplexer_16to1 #(.M(M)) u_mux (
    .in_data  (w_mux_in),
    .sel      (w_sel),
    .out_data (out_data)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_load) w_state_nxt = SERIAL;
      end
      SERIAL: begin
        if (w_beat && w_at_last) w_state_nxt = w_load ? SERIAL : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_vec   <= '0;
      r_last  <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_vec  <= in_data;
        r_last <= in_last_idx;
        r_idx  <= '0;
      end else if (w_beat && !w_at_last) begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_vector_serializer_16.sv
`default_nettype none
// ============================================================================
// Module   : tb_vector_serializer_16
// Purpose  : Directed scoreboard bench for vector_serializer_16 (M=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vector_serializer_16;
  localparam int M = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [16*M-1:0] in_data;
  logic [3:0]     in_last_idx;
  logic           out_valid;
  logic           out_ready;
  logic [M-1:0]   out_data;
  logic           out_last;
  logic           busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int hs_cyc = 0;
  logic [M:0] sb_q[$];
  int beat_cyc[$];

  vector_serializer_16 #(.M(M)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_last_idx (in_last_idx),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: every accepted beat is compared against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      beat_cyc.push_back(cyc);
      if (sb_q.size() == 0) begin
        chk("unexpected_beat", {23'd0, out_last, out_data}, 32'hDEAD);
      end else begin
        logic [M:0] e;
        e = sb_q.pop_front();
        chk("beat_data", {24'd0, out_data}, {24'd0, e[M-1:0]});
        chk("beat_last", {31'd0, out_last}, {31'd0, e[M]});
      end
    end
  end

  function automatic logic [16*M-1:0] mkvec(input logic [7:0] base);
    logic [16*M-1:0] v;
    for (int k = 0; k < 16; k++) v[k*M +: M] = base + 8'(k);
    return v;
  endfunction

  task automatic send(input logic [16*M-1:0] v, input logic [3:0] l);
    int n;
    in_valid    = 1'b1;
    in_data     = v;
    in_last_idx = l;
    for (int k = 0; k <= int'(l); k++) sb_q.push_back({(k == int'(l)), v[k*M +: M]});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 300);
    if (!in_ready) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    hs_cyc   = cyc;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 300 && sb_q.size() != 0; n++) @(posedge clk);
    chk("drain_empty", sb_q.size(), 32'd0);
    #1;
  endtask

  initial begin
    logic [16*M-1:0] v;
    int h1;
    rst = 1'b1; in_valid = 1'b1; in_data = '0; in_last_idx = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_last",  {31'd0, out_last},  32'd0);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // 1: full 16-element vector streams 1..16 back to back
    beat_cyc.delete();
    send(mkvec(8'd1), 4'd15);
    drain();
    chk("t1_beats", beat_cyc.size(), 32'd16);
    if (beat_cyc.size() == 16) begin
      chk("t1_latency", beat_cyc[0], hs_cyc);
      chk("t1_span", beat_cyc[15] - beat_cyc[0], 32'd15);
    end

    // 2: single element vector
    v = mkvec(8'hF0); v[7:0] = 8'hA5;
    send(v, 4'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t2_in_ready", {31'd0, in_ready}, 32'd1);
    chk("t2_busy", {31'd0, busy}, 32'd0);
    chk("t2_sb_empty", sb_q.size(), 32'd0);
    @(posedge clk); #1;

    // 3: two vectors back to back, no bubble
    beat_cyc.delete();
    send(mkvec(8'h20), 4'd3);
    h1 = hs_cyc;
    send(mkvec(8'h40), 4'd3);
    chk("t3_second_hs", hs_cyc - h1, 32'd4);
    drain();
    chk("t3_beats", beat_cyc.size(), 32'd8);
    if (beat_cyc.size() == 8) chk("t3_span", beat_cyc[7] - beat_cyc[0], 32'd7);

    // 4: stall on element 2 for two cycles
    send(mkvec(8'h60), 4'd5);
    @(posedge clk); #1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("t4_hold0", {24'd0, out_data}, 32'h62);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4_hold1", {24'd0, out_data}, 32'h62);
    chk("t4_valid", {31'd0, out_valid}, 32'd1);
    chk("t4_last", {31'd0, out_last}, 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t4_hold2", {24'd0, out_data}, 32'h62);
    drain();

    // 5: reset in the middle of a vector
    send(mkvec(8'h80), 4'd15);
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    chk("t5_idx5", {24'd0, out_data}, 32'h85);
    chk("t5_rdy_in_rst", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    sb_q.delete();
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("t5_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    send(mkvec(8'h90), 4'd2);
    drain();

    // 6: in_valid while stalled mid-vector must be ignored
    out_ready = 1'b0;
    send(mkvec(8'hB0), 4'd3);
    in_valid = 1'b1; in_data = {16{8'hEE}}; in_last_idx = 4'd0;
    repeat (3) begin
      @(negedge clk);
      chk("t6_in_ready", {31'd0, in_ready}, 32'd0);
      chk("t6_data", {24'd0, out_data}, 32'hB0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    drain();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t6_idle", {31'd0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
